// File: rtl/jam_cost_loader.sv
// jam_cost_loader: streams an 8x8 cost matrix in from a host, holds JAM in
// reset while loading, serves JAM's cost lookups and captures its result.
module jam_cost_loader #(
  parameter int CYC_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  input  logic [6:0]       in_data,
  output logic             in_ready,
  input  logic [2:0]       W,
  input  logic [2:0]       J,
  output logic [6:0]       Cost,
  output logic             JamRst,
  input  logic             Valid,
  input  logic [9:0]       MinCost,
  input  logic [3:0]       MatchCount,
  output logic [9:0]       ResCost,
  output logic [3:0]       ResCount,
  output logic [CYC_W-1:0] ResCycles,
  output logic             ResDone
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CYC_W-1:0] CNT_MAX = {CYC_W{1'b1}};

  state_t           state;
  logic [5:0]       idx;
  logic [CYC_W-1:0] cnt;
  logic [6:0]       mem [64];

  logic accept;
  logic last_word;
  logic cnt_sat;

  // a host word lands only while loading; in_ready mirrors that state
  assign accept    = (state == S_LOAD) & in_valid;
  assign last_word = accept & (idx == 6'd63);
  assign cnt_sat   = (cnt == CNT_MAX);

  // JAM looks up costs combinationally; no bypass of same-cycle writes
  assign Cost = mem[{W, J}];

  // cost storage, cleared by reset so a partial load never leaks through
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < 64; k++) begin
        mem[k] <= 7'd0;
      end
    end else if (accept) begin
      mem[idx] <= in_data;
    end
  end

  // load/run/done sequencer with registered handshake and result outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= S_LOAD;
      idx       <= 6'd0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      JamRst    <= 1'b1;
      ResDone   <= 1'b0;
      ResCost   <= 10'd0;
      ResCount  <= 4'd0;
      ResCycles <= '0;
    end else begin
      unique case (state)
        S_LOAD: begin
          ResDone <= 1'b0;
          if (accept) begin
            idx <= idx + 6'd1;
          end
          if (last_word) begin
            state    <= S_RUN;
            in_ready <= 1'b0;
            JamRst   <= 1'b0;
            cnt      <= '0;
          end
        end
        S_RUN: begin
          if (Valid) begin
            state     <= S_DONE;
            JamRst    <= 1'b1;
            ResDone   <= 1'b1;
            ResCost   <= MinCost;
            ResCount  <= MatchCount;
            ResCycles <= cnt;
          end else if (!cnt_sat) begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          state    <= S_LOAD;
          in_ready <= 1'b1;
          ResDone  <= 1'b0;
        end
        default: begin
          state    <= S_LOAD;
          idx      <= 6'd0;
          in_ready <= 1'b1;
          JamRst   <= 1'b1;
          ResDone  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jam_cost_loader.sv
// tb_jam_cost_loader: vector table plus randomized loads against a
// cycle model of the loader, with a scripted stand-in for JAM.
`timescale 1ns/1ps
module tb_jam_cost_loader;

  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          CLK;
  logic          RST;
  logic          in_valid;
  logic [6:0]    in_data;
  logic          in_ready;
  logic [2:0]    W;
  logic [2:0]    J;
  logic [6:0]    Cost;
  logic          JamRst;
  logic          Valid;
  logic [9:0]    MinCost;
  logic [3:0]    MatchCount;
  logic [9:0]    ResCost;
  logic [3:0]    ResCount;
  logic [CW-1:0] ResCycles;
  logic          ResDone;

  jam_cost_loader #(.CYC_W(CW)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .W(W), .J(J), .Cost(Cost), .JamRst(JamRst),
    .Valid(Valid), .MinCost(MinCost), .MatchCount(MatchCount),
    .ResCost(ResCost), .ResCount(ResCount),
    .ResCycles(ResCycles), .ResDone(ResDone)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  // reference model: words accepted so far, phase flags, run length
  logic [6:0] m_mat [64];
  int         m_words;
  bit         m_load, m_run, m_done;
  int         m_len;
  logic [9:0] m_cost;
  logic [3:0] m_cnt;
  int         m_cyc;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int k = 0; k < 64; k++) m_mat[k] <= 7'd0;
      m_words <= 0;
      m_load  <= 1;
      m_run   <= 0;
      m_done  <= 0;
      m_len   <= 0;
      m_cost  <= 0;
      m_cnt   <= 0;
      m_cyc   <= 0;
    end else if (m_done) begin
      m_done <= 0;
      m_load <= 1;
    end else if (m_load) begin
      if (in_valid) begin
        m_mat[m_words] <= in_data;
        if (m_words == 63) begin
          m_words <= 0;
          m_load  <= 0;
          m_run   <= 1;
          m_len   <= 0;
        end else begin
          m_words <= m_words + 1;
        end
      end
    end else if (m_run) begin
      if (Valid) begin
        m_cost <= MinCost;
        m_cnt  <= MatchCount;
        m_cyc  <= (m_len > CMAX) ? CMAX : m_len;
        m_run  <= 0;
        m_done <= 1;
      end else begin
        m_len <= m_len + 1;
      end
    end
  end

  always @(negedge CLK) begin
    if (started) begin
      chk("in_ready", in_ready, m_load);
      chk("JamRst", JamRst, !m_run);
      chk("ResDone", ResDone, m_done);
      chk("ResCost", ResCost, m_cost);
      chk("ResCount", ResCount, m_cnt);
      chk("ResCycles", ResCycles, m_cyc);
      chk("Cost", Cost, m_mat[{W, J}]);
    end
  end

  typedef struct {
    logic [2:0] w;
    logic [2:0] j;
    logic [6:0] exp;
  } vec_t;

  vec_t       tbl [8];
  logic [6:0] wd  [64];
  int         cyc;

  task automatic load(input int n, input int mode, output int ncyc);
    int  i;
    bit  v;
    bit  acc;
    i    = 0;
    ncyc = 0;
    while (i < n && ncyc < 2000) begin
      W = 3'($urandom);
      J = 3'($urandom);
      if (mode == 0) v = 1;
      else if (mode == 1) v = (ncyc % 2 == 1);
      else v = ($urandom % 3) != 0;
      if (mode == 2) Valid = 1'($urandom);
      in_valid = v;
      in_data  = v ? wd[i] : 7'($urandom);
      acc = v && in_ready;
      @(posedge CLK);
      #1;
      ncyc++;
      if (acc) i++;
    end
    in_valid = 0;
    Valid    = 0;
    if (i < n) begin
      errors++;
      $display("FAIL load_timeout got %0d want %0d", i, n);
    end
  endtask

  task automatic jam(input int pre, input int d, input logic [9:0] mc,
                     input logic [3:0] cnt);
    int e;
    e = (pre + d > CMAX) ? CMAX : pre + d;
    chk("run_jamrst", JamRst, 0);
    chk("run_ready", in_ready, 0);
    repeat (d) begin
      W = 3'($urandom);
      J = 3'($urandom);
      in_valid = 1'($urandom);
      in_data  = 7'($urandom);
      @(posedge CLK);
      #1;
    end
    Valid      = 1;
    MinCost    = mc;
    MatchCount = cnt;
    @(posedge CLK);
    #1;
    chk("done_pulse", ResDone, 1);
    chk("done_jamrst", JamRst, 1);
    chk("done_ready", in_ready, 0);
    chk("done_cost", ResCost, mc);
    chk("done_count", ResCount, cnt);
    chk("done_cycles", ResCycles, e);
    Valid      = 0;
    in_valid   = 0;
    MinCost    = 10'($urandom);
    MatchCount = 4'($urandom);
    @(posedge CLK);
    #1;
    chk("after_ready", in_ready, 1);
    chk("after_pulse", ResDone, 0);
    chk("after_jamrst", JamRst, 1);
    chk("after_cost", ResCost, mc);
  endtask

  task automatic reset_mid;
    @(posedge CLK);
    #3;
    RST = 0;
    #1;
    chk("rst_ready", in_ready, 1);
    chk("rst_jamrst", JamRst, 1);
    chk("rst_cost", ResCost, 0);
    chk("rst_count", ResCount, 0);
    chk("rst_cycles", ResCycles, 0);
    chk("rst_done", ResDone, 0);
    for (int k = 0; k < 64; k++) begin
      W = 3'(k / 8);
      J = 3'(k % 8);
      #1;
      chk("rst_mat", Cost, 0);
    end
    @(posedge CLK);
    #1;
    RST = 1;
  endtask

  initial begin
    tbl[0] = '{3'd5, 3'd3, 7'd43};
    tbl[1] = '{3'd0, 3'd0, 7'd0};
    tbl[2] = '{3'd7, 3'd7, 7'd63};
    tbl[3] = '{3'd0, 3'd7, 7'd7};
    tbl[4] = '{3'd7, 3'd0, 7'd56};
    tbl[5] = '{3'd2, 3'd5, 7'd21};
    tbl[6] = '{3'd4, 3'd4, 7'd36};
    tbl[7] = '{3'd1, 3'd0, 7'd8};

    RST        = 0;
    in_valid   = 0;
    in_data    = 0;
    W          = 0;
    J          = 0;
    Valid      = 0;
    MinCost    = 0;
    MatchCount = 0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1;
    started = 1;
    #1;
    chk("init_ready", in_ready, 1);
    chk("init_jamrst", JamRst, 1);
    chk("init_cost", Cost, 0);

    // ascending matrix, host never idles
    for (int i = 0; i < 64; i++) wd[i] = 7'(i);
    load(64, 0, cyc);
    chk("load_cycles", cyc, 64);
    for (int t = 0; t < 8; t++) begin
      W = tbl[t].w;
      J = tbl[t].j;
      #1;
      chk("tbl_cost", Cost, tbl[t].exp);
      @(posedge CLK);
      #1;
    end
    jam(8, 3, 10'd77, 4'd5);

    // host idles every other cycle; read everything back
    for (int i = 0; i < 64; i++) wd[i] = 7'($urandom);
    load(64, 1, cyc);
    chk("bubble_cycles", cyc, 128);
    for (int k = 0; k < 64; k++) begin
      W = 3'(k / 8);
      J = 3'(k % 8);
      #1;
      chk("readback", Cost, wd[k]);
      @(posedge CLK);
      #1;
    end
    jam(64, 2, 10'd300, 4'd9);

    // diagonal matrix
    for (int i = 0; i < 64; i++) wd[i] = (i / 8 == i % 8) ? 7'd0 : 7'd100;
    load(64, 2, cyc);
    jam(0, 5, 10'd0, 4'd1);

    // uniform matrix: every assignment ties
    for (int i = 0; i < 64; i++) wd[i] = 7'd10;
    load(64, 0, cyc);
    jam(0, 7, 10'd80, 4'd0);
    chk("cycles_nonzero", ResCycles != 0, 1);

    // partial load abandoned by reset, then a clean diagonal load
    for (int i = 0; i < 64; i++) wd[i] = 7'd55;
    load(30, 0, cyc);
    reset_mid();
    for (int i = 0; i < 64; i++) wd[i] = (i / 8 == i % 8) ? 7'd0 : 7'd100;
    load(64, 0, cyc);
    chk("diag_w0j0", dut.Cost, m_mat[{W, J}]);
    W = 3'd3;
    J = 3'd3;
    #1;
    chk("diag_33", Cost, 0);
    W = 3'd3;
    J = 3'd4;
    #1;
    chk("diag_34", Cost, 100);
    @(posedge CLK);
    #1;
    jam(1, 5, 10'd0, 4'd1);

    // randomized runs
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 64; i++) wd[i] = 7'($urandom);
      load(64, 2, cyc);
      jam(0, int'($urandom_range(0, 70)), 10'($urandom), 4'($urandom));
    end

    repeat (2) @(posedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
